instr_fetch_unit: RTL

- Upstream neighbour of the decode/immediate-extension logic in the RISC-V core.
- Owns the fetch PC and issues word-aligned requests to instruction memory over a valid/ready request channel.
- Collects in-order responses into a small instruction buffer and presents instruction, PC and PC+4 to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffer and discarding stale in-flight responses.

---
 rtl/instr_fetch_unit_pkg.sv | 23 ++
 rtl/instr_fetch_unit_if.sv | 35 +++
 rtl/instr_fetch_unit_sync_fifo.sv | 74 +++++++
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: data widths, reset PC and
// the buffered fetch entry.
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // RUN delivers responses; DRAIN drops responses that predate a redirect.
  typedef enum logic {
    RUN,
    DRAIN
  } drain_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// The fetch unit connects through the master modport.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_resp_valid_i;
  logic [XLEN-1:0] imem_resp_data_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [XLEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic [XLEN-1:0] instr_pc_plus4_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i,
    input  redirect_i, redirect_pc_i,
    output instr_valid_o, instr_o, instr_pc_o, instr_pc_plus4_o,
    input  instr_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i,
    output redirect_i, redirect_pc_i,
    input  instr_valid_o, instr_o, instr_pc_o, instr_pc_plus4_o,
    output instr_ready_i
  );

endinterface

// File: rtl/instr_fetch_unit_sync_fifo.sv
// Small synchronous FIFO with occupancy count, same-cycle push/pop and a
// flush that empties it in one cycle. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en, pop_en;

  assign full_o     = (count_q == COUNT_FULL);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_en = push_i && (!full_o || pop_i);
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W + 1)'(push_en) - (PTR_W + 1)'(pop_en);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count_q alone,
  // which keeps the array a plain register file or RAM.
  always_ff @(posedge clk_i) begin
    if (push_en && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues credit-limited word requests,
// buffers in-order responses for decode and drains stale ones after a redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  instr_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(BUF_DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  drain_state_e     state_q, state_d;

  logic [CNT_W-1:0] outstanding, buf_count;
  logic [CNT_W:0]   credit_used;
  logic             req_fire, resp_drop, buf_push, buf_pop;
  logic             buf_full, buf_empty, tag_full, tag_empty;
  fetch_entry_t     buf_in, buf_head;
  logic [XLEN-1:0]  tag_head;

  // Outstanding plus buffered never exceeds BUF_DEPTH, so every response has a slot.
  assign credit_used = {1'b0, outstanding} + {1'b0, buf_count};
  assign bus.imem_req_valid_o = !rst_i && !bus.redirect_i && (credit_used < CREDIT_LIMIT);
  assign bus.imem_req_addr_o  = word_align(fetch_pc_q);

  assign req_fire  = bus.imem_req_valid_o && bus.imem_req_ready_i;
  assign resp_drop = bus.imem_resp_valid_i && ((state_q == DRAIN) || bus.redirect_i);
  assign buf_push  = bus.imem_resp_valid_i && !resp_drop;
  assign buf_pop   = !buf_empty && bus.instr_ready_i;
  assign buf_in    = '{instr: bus.imem_resp_data_i, pc: tag_head};

  // The tag FIFO occupancy is the outstanding-request count.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (1'b0),
    .push_i      (req_fire),
    .push_data_i (fetch_pc_q),
    .pop_i       (bus.imem_resp_valid_i),
    .pop_data_o  (tag_head),
    .count_o     (outstanding),
    .full_o      (tag_full),
    .empty_o     (tag_empty)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_instr_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (bus.redirect_i),
    .push_i      (buf_push),
    .push_data_i (buf_in),
    .pop_i       (buf_pop),
    .pop_data_o  (buf_head),
    .count_o     (buf_count),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (bus.redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = word_align(bus.redirect_pc_i);
      discard_d  = outstanding - CNT_W'(bus.imem_resp_valid_i);
    end else begin
      if (req_fire)  fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_drop) discard_d  = discard_q - CNT_W'(1);
    end
    state_d = (discard_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
      state_q    <= RUN;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      state_q    <= state_d;
    end
  end

  assign bus.instr_valid_o    = !buf_empty;
  assign bus.instr_o          = buf_empty ? '0 : buf_head.instr;
  assign bus.instr_pc_o       = buf_empty ? '0 : buf_head.pc;
  assign bus.instr_pc_plus4_o = buf_empty ? '0 : buf_head.pc + XLEN'(4);

  a_resp_has_tag : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.imem_resp_valid_i |-> !tag_empty);
  a_req_has_tag_slot : assert property (@(posedge clk_i) disable iff (rst_i)
    req_fire |-> !tag_full);
  a_push_has_slot : assert property (@(posedge clk_i) disable iff (rst_i)
    buf_push |-> (!buf_full || buf_pop));
  a_discard_bounded : assert property (@(posedge clk_i) disable iff (rst_i)
    discard_q <= outstanding);

endmodule
